// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row strobing, column sync, scan-level debounce, press pulse.
// Optional auto-repeat of key_pulse is built only when KEY_REPEAT_EN is defined.
module keypad_scan #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [4:0] key,
  output logic [4:0] key_pulse
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     STAB_ACC = 4'(DEBOUNCE_CNT - 1);

  typedef enum logic {REL, PRS} state_e;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic          tc, scan_done;
  logic          acc_vld_q, acc_vld_d;
  logic [3:0]    acc_idx_q, acc_idx_d;
  logic [3:0]    pressed;
  logic          hit;
  logic [1:0]    col_idx;
  logic [4:0]    scan_res;
  logic [4:0]    prev_q, prev_d;
  logic [3:0]    stab_q, stab_d;
  logic          accept;
  logic          rpt_fire;
  state_e        state_q, state_d;
  logic [4:0]    key_q, key_d, pulse_q, pulse_d;

  assign key_row   = ~(4'b0001 << row_q);
  assign key       = key_q;
  assign key_pulse = pulse_q;

  assign tc        = (div_q == DIV_LAST);
  assign scan_done = tc && (row_q == 2'd3);
  assign pressed   = ~col_s2_q;
  assign hit       = |pressed;

  always_comb begin
    col_idx = 2'd3;
    if (pressed[2]) col_idx = 2'd2;
    if (pressed[1]) col_idx = 2'd1;
    if (pressed[0]) col_idx = 2'd0;
  end

  always_comb begin
    div_d = tc ? '0 : div_q + 1'b1;
    row_d = tc ? row_q + 2'd1 : row_q;
  end

  // Rows are visited in index order, so the first hit recorded is the lowest index.
  always_comb begin
    acc_vld_d = acc_vld_q;
    acc_idx_d = acc_idx_q;
    scan_res  = '0;
    if (tc && !acc_vld_q && hit) begin
      acc_vld_d = 1'b1;
      acc_idx_d = {row_q, col_idx};
    end
    if (scan_done) begin
      scan_res  = {acc_vld_d, acc_idx_d};
      acc_vld_d = 1'b0;
      acc_idx_d = '0;
    end
  end

  always_comb begin
    prev_d = prev_q;
    stab_d = stab_q;
    accept = 1'b0;
    if (scan_done) begin
      prev_d = scan_res;
      if (scan_res == prev_q) stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
      else                    stab_d = '0;
      accept = (stab_d >= STAB_ACC) && (scan_res != key_q);
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS) + 1;
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;

  assign rpt_inc = rpt_q + 1'b1;

  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (state_q != PRS || accept) begin
      rpt_d = '0;
    end else if (scan_done) begin
      if (rpt_inc == RW'(REPEAT_SCANS)) begin
        rpt_d    = '0;
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q  <= 4'hF;
      col_s2_q  <= 4'hF;
      div_q     <= '0;
      row_q     <= '0;
      acc_vld_q <= 1'b0;
      acc_idx_q <= '0;
      prev_q    <= '0;
      stab_q    <= '0;
      state_q   <= REL;
      key_q     <= '0;
      pulse_q   <= '0;
    end else begin
      col_s1_q  <= key_col;
      col_s2_q  <= col_s1_q;
      div_q     <= div_d;
      row_q     <= row_d;
      acc_vld_q <= acc_vld_d;
      acc_idx_q <= acc_idx_d;
      prev_q    <= prev_d;
      stab_q    <= stab_d;
      state_q   <= state_d;
      key_q     <= key_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REL:     if (accept && scan_res[4])  state_d = PRS;
      PRS:     if (accept && !scan_res[4]) state_d = REL;
      default: state_d = REL;
    endcase
  end

  // A release acceptance loads key with 0 and, since the pulse mirrors the result, emits nothing.
  always_comb begin
    key_d   = key_q;
    pulse_d = '0;
    if (accept) begin
      key_d   = scan_res;
      pulse_d = scan_res;
    end else if (rpt_fire && state_q == PRS) begin
      pulse_d = key_q;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a scan-level model queues expected key/pulse events,
// a monitor pops them as the DUT outputs change.
module tb_keypad_scan;
  localparam int SD = 4, DB = 3, RS = 4;
  localparam int SCAN_CLK = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_col, key_row;
  logic [4:0] key, key_pulse;
  logic [15:0] mask = '0;
  int  checks = 0, failures = 0;
  int  cyc;
  bit  done = 1'b0;

  typedef struct {
    logic [4:0] k;
    logic [4:0] p;
    int         at;
  } ev_t;
  ev_t evq[$];

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_SCANS(RS)) dut (
    .clk(clk), .rst(rst), .key_col(key_col),
    .key_row(key_row), .key(key), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Physical matrix: a held key pulls its column low while its row is strobed.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!key_row[r])
        for (int c = 0; c < 4; c++)
          if (mask[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: row rotation every cycle, key/pulse events against the queue.
  initial begin
    logic [4:0] seen;
    logic [3:0] exp_row;
    bit         in_rst;
    bit         fin;
    ev_t        e;
    seen = '0; in_rst = 1'b0; fin = 1'b0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          #1;
          check("rst_key", 32'(key), 32'h0);
          check("rst_pulse", 32'(key_pulse), 32'h0);
          check("rst_row", 32'(key_row), 32'hE);
          check("rst_queue_empty", 32'(evq.size()), 32'h0);
          evq.delete();
        end
        seen = '0;
      end else begin
        in_rst  = 1'b0;
        exp_row = ~(4'b0001 << ((cyc / 4) % 4));
        check("row_strobe", 32'(key_row), 32'(exp_row));
        while (evq.size() > 0 && evq[0].at < cyc) begin
          e = evq.pop_front();
          check("missing_event_cycle", 32'(cyc), 32'(e.at));
        end
        if (key !== seen || key_pulse !== 5'h0) begin
          if (evq.size() == 0) begin
            check("unexpected_output", {22'h0, key, key_pulse}, {22'h0, seen, 5'h0});
          end else begin
            e = evq.pop_front();
            check("event_cycle", 32'(cyc), 32'(e.at));
            check("event_key", 32'(key), 32'(e.k));
            check("event_pulse", 32'(key_pulse), 32'(e.p));
          end
          seen = key;
        end
        if (done && !fin) begin
          fin = 1'b1;
          check("queue_drained", 32'(evq.size()), 32'h0);
        end
      end
    end
  end

  // Reference model, one step per full scan: run length of identical results decides acceptance.
  logic [4:0] m_prev, m_key;
  int         m_run, s;
`ifdef KEY_REPEAT_EN
  int         m_rpt;
`endif

  task automatic model_reset();
    m_prev = '0; m_key = '0; m_run = 1; s = 0;
`ifdef KEY_REPEAT_EN
    m_rpt = 0;
`endif
  endtask

  task automatic do_scan(input logic [15:0] m);
    logic [4:0] res;
    ev_t        e;
    res = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) res = {1'b1, 4'(i)};
    mask = m;
    if (res == m_prev) m_run++; else m_run = 1;
    m_prev = res;
    e.at = SCAN_CLK * (s + 1);
    if (m_run >= DB && res != m_key) begin
      e.k = res; e.p = res;
      evq.push_back(e);
      m_key = res;
`ifdef KEY_REPEAT_EN
      m_rpt = 0;
`endif
    end
`ifdef KEY_REPEAT_EN
    else if (m_key != 5'h0) begin
      m_rpt++;
      if (m_rpt == RS) begin
        m_rpt = 0;
        e.k = m_key; e.p = m_key;
        evq.push_back(e);
      end
    end
`endif
    s++;
    repeat (SCAN_CLK) @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) do_scan(m);
  endtask

  // Reset lands in row 2 of a scan; the partial scan produces nothing.
  task automatic mid_reset(input logic [15:0] m);
    mask = m;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] m;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    hold(16'h0000, 10);
    hold(16'h0020, 5);
    hold(16'h0000, 5);
    hold(16'h0008, 2);
    hold(16'h0000, 5);
    hold(16'h000A, 5);
    hold(16'h0008, 5);
    hold(16'h0000, 4);
    hold(16'h0020, 4);
    mid_reset(16'h0020);
    hold(16'h0020, 12);
    hold(16'h0000, 4);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = 16'(1) << $urandom_range(0, 15);
        2:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: m = 16'($urandom) & 16'($urandom);
      endcase
      hold(m, $urandom_range(1, 5));
    end
    hold(16'h0000, 5);
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
